// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square frame receiver: marker word, FSM
// state encoding and the 33-bit sample record carried through the output FIFO.
package fast_square_pkg;

  localparam int          DATA_W      = 16;
  localparam logic [15:0] MARKER_WORD = 16'h8000;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_MARKER = 2'd1,
    ST_FRAME  = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [DATA_W-1:0] i;
    logic signed [DATA_W-1:0] q;
    logic                     last;
  } sample_t;

  function automatic logic is_marker(input logic [DATA_W-1:0] i_val,
                                     input logic [DATA_W-1:0] q_val);
    return (i_val == MARKER_WORD) && (q_val == MARKER_WORD);
  endfunction

endpackage

// File: rtl/fast_square_sample_fifo.sv
// Synchronous show-ahead FIFO of (I, Q, last) samples. The head is held in a
// register so it resets to zero and keeps its value while the FIFO is empty.
module fast_square_sample_fifo
  import fast_square_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    i_push,
  input  sample_t i_push_data,
  input  logic    i_pop,
  output sample_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);

  sample_t       r_mem [DEPTH];
  sample_t       r_head;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;

  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_rd_next;
  logic [AW:0]   w_cnt_after_pop;
  sample_t       w_head_next;

  assign o_empty         = (r_count == '0);
  assign o_full          = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop        = i_pop && !o_empty;
  assign w_do_push       = i_push && (!o_full || w_do_pop);
  assign w_rd_next       = r_rd + AW'(w_do_pop);
  assign w_cnt_after_pop = r_count - (AW+1)'(w_do_pop);
  assign o_head          = r_head;

  // Next head: oldest surviving entry, else the incoming sample, else hold.
  always_comb begin
    w_head_next = r_head;
    if (w_cnt_after_pop != '0)
      w_head_next = r_mem[w_rd_next];
    else if (w_do_push)
      w_head_next = i_push_data;
  end

  always_ff @(posedge clock) begin
    if (w_do_push)
      r_mem[r_wr] <= i_push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_head  <= '0;
    end else begin
      r_head <= w_head_next;
      r_rd   <= w_rd_next;
      if (w_do_push)
        r_wr <= r_wr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fast_square_frame_rx.sv
// Frame receiver: hunts for a run of marker samples, then captures FRAME_LEN
// samples into the output FIFO. Define FAST_SQUARE_FRAME_RX_STATS_EN to add frame_count.
module fast_square_frame_rx
  import fast_square_pkg::*;
#(
  parameter int MARKER_MIN = 16,
  parameter int FRAME_LEN  = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_strobe,
  input  logic signed [DATA_W-1:0] i_in,
  input  logic signed [DATA_W-1:0] q_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_i,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     out_last,
  output logic                     sync_lost,
  output logic                     overflow
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  localparam int RUN_W = $clog2(MARKER_MIN + 1);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MARKER_MIN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [RUN_W-1:0] r_run;
  logic [IDX_W-1:0] r_idx;
  logic             r_sync_lost;
  logic             r_overflow;

  logic             w_marker;
  logic             w_data;
  logic             w_armed;
  logic             w_push;
  logic [IDX_W-1:0] w_push_idx;
  logic             w_last;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  sample_t          w_push_data;
  sample_t          w_head;

  assign w_marker    = in_strobe && is_marker(i_in, q_in);
  assign w_data      = in_strobe && !w_marker;
  assign w_armed     = (r_run >= RUN_MAX);
  assign w_push      = w_data && ((r_state == ST_FRAME) ||
                                  ((r_state == ST_MARKER) && w_armed));
  assign w_push_idx  = (r_state == ST_FRAME) ? r_idx : '0;
  assign w_last      = (w_push_idx == IDX_LAST);
  assign w_push_data = '{i: i_in, q: q_in, last: w_last};
  // A full FIFO only makes room when the consumer pops in the same cycle.
  assign w_drop      = w_push && w_full && !out_ready;

  fast_square_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (out_ready),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_i     = w_head.i;
  assign out_q     = w_head.q;
  assign out_last  = w_head.last;
  assign sync_lost = r_sync_lost;
  assign overflow  = r_overflow;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_run       <= '0;
      r_idx       <= '0;
      r_sync_lost <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_sync_lost <= 1'b0;
      if (w_drop)
        r_overflow <= 1'b1;
      case (r_state)
        ST_HUNT: begin
          if (w_marker) begin
            r_state <= ST_MARKER;
            r_run   <= RUN_W'(1);
          end
        end
        ST_MARKER: begin
          if (w_marker) begin
            if (r_run < RUN_MAX)
              r_run <= r_run + RUN_W'(1);
          end else if (w_data) begin
            r_run <= '0;
            if (w_armed && !w_last) begin
              r_state <= ST_FRAME;
              r_idx   <= IDX_W'(1);
            end else begin
              r_state <= ST_HUNT;
              r_idx   <= '0;
            end
          end
        end
        ST_FRAME: begin
          if (w_marker) begin
            r_state     <= ST_MARKER;
            r_run       <= RUN_W'(1);
            r_idx       <= '0;
            r_sync_lost <= 1'b1;
          end else if (w_data) begin
            if (w_last) begin
              r_state <= ST_HUNT;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= ST_HUNT;
          r_run   <= '0;
          r_idx   <= '0;
        end
      endcase
    end
  end

`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clock) begin
    if (reset)
      r_frame_count <= '0;
    else if (w_push && w_last && !w_drop)
      r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_fast_square_frame_rx.sv
// Scoreboard bench for fast_square_frame_rx: directed marker/frame sequences
// push expected samples; a negedge monitor pops and compares on each transfer.
module tb_fast_square_frame_rx;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               in_strobe = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic               out_last;
  logic               sync_lost;
  logic               overflow;
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
  logic [15:0]        frame_count;
`endif

  logic [32:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_sync  = 0;

  fast_square_frame_rx #(
    .MARKER_MIN (16),
    .FRAME_LEN  (64),
    .FIFO_DEPTH (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_strobe (in_strobe),
    .i_in      (i_in),
    .q_in      (q_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_i     (out_i),
    .out_q     (out_q),
    .out_last  (out_last),
    .sync_lost (sync_lost),
    .overflow  (overflow)
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] smp(input int i, input int q, input bit last);
    return {16'(i), 16'(q), last};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: a transfer happens on the coming edge when valid && ready now.
  always @(negedge clock) begin : monitor
    logic [32:0] e;
    if (sync_lost === 1'b1)
      n_sync++;
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got i=%0h q=%0h last=%0b, none expected",
                 out_i, out_q, out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_i, out_q, out_last} !== e) begin
          n_fail++;
          $display("FAIL sample: got i=%0h q=%0h last=%0b expected i=%0h q=%0h last=%0b",
                   out_i, out_q, out_last, e[32:17], e[16:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input int i, input int q);
    in_strobe = 1'b1;
    i_in      = 16'(i);
    q_in      = 16'(q);
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic markers(input int n);
    repeat (n) strobe(32'h8000, 32'h8000);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({nm, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 0);
    check("rst_i", 32'(out_i), 0);
    check("rst_q", 32'(out_q), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_sync", 32'(sync_lost), 0);
    check("rst_ovf", 32'(overflow), 0);
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("rst_fc", 32'(frame_count), 0);
`endif
    reset = 1'b0;
    out_ready = 1'b1;

    // Long marker run then ramp frame
    markers(200);
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(smp(n, -n, n == 63));
      strobe(n, -n);
      if (n == 0) begin
        check("lat_valid", 32'(out_valid), 1);
        check("lat_i", 32'(out_i), 0);
      end
    end
    drain("t1");
    check("t1_ovf", 32'(overflow), 0);
    check("t1_sync", 32'(n_sync), 0);
    check("t1_hold_i", 32'(out_i), 63);
    check("t1_hold_last", 32'(out_last), 1);
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t1_fc", 32'(frame_count), 1);
`endif

    // Short marker run is rejected, then a proper run is accepted
    markers(10);
    strobe(5, 5);
    markers(16);
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(smp(100 + n, n, n == 63));
      strobe(100 + n, n);
    end
    drain("t2");
    check("t2_sync", 32'(n_sync), 0);

    // Marker at index 30 aborts the frame
    markers(16);
    for (int n = 0; n < 30; n++) begin
      exp_q.push_back(smp(32'h200 + n, n, 0));
      strobe(32'h200 + n, n);
    end
    markers(1);
    check("t3_sync_pulse", 32'(sync_lost), 1);
    tick();
    check("t3_sync_end", 32'(sync_lost), 0);
    markers(15);
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(smp(32'h300 + n, n, n == 63));
      strobe(32'h300 + n, n);
    end
    drain("t3");
    check("t3_sync_count", 32'(n_sync), 1);
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t3_fc", 32'(frame_count), 3);
`endif

    // Consumer stalled for a whole frame: first 16 kept, rest dropped
    out_ready = 1'b0;
    markers(16);
    for (int n = 0; n < 64; n++) begin
      if (n < 16) exp_q.push_back(smp(32'h400 + n, 32'h1000 + n, 0));
      strobe(32'h400 + n, 32'h1000 + n);
    end
    check("t4_valid", 32'(out_valid), 1);
    check("t4_head_stable", 32'(out_i), 32'h400);
    check("t4_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    drain("t4");
    check("t4_ovf_sticky", 32'(overflow), 1);
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t4_fc", 32'(frame_count), 3);
`endif

    // Push and pop together while full: nothing dropped
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("t5_ovf_clr", 32'(overflow), 0);
    out_ready = 1'b0;
    markers(16);
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(smp(32'h500 + n, n, n == 63));
      if (n >= 16) out_ready = 1'b1;
      strobe(32'h500 + n, n);
      out_ready = 1'b0;
    end
    check("t5_ovf", 32'(overflow), 0);
    out_ready = 1'b1;
    drain("t5");
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t5_fc", 32'(frame_count), 1);
`endif

    // Reset mid-frame at index 40 discards queued samples
    markers(16);
    for (int n = 0; n < 30; n++) begin
      exp_q.push_back(smp(32'h600 + n, n, 0));
      strobe(32'h600 + n, n);
    end
    tick();
    out_ready = 1'b0;
    for (int n = 30; n < 40; n++) strobe(32'h600 + n, n);
    check("t6_pre_valid", 32'(out_valid), 1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_i", 32'(out_i), 0);
    check("t6_rst_last", 32'(out_last), 0);
    check("t6_rst_sync", 32'(sync_lost), 0);
    reset = 1'b0;
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t6_fc_rst", 32'(frame_count), 0);
`endif
    out_ready = 1'b1;
    for (int n = 0; n < 64; n++) strobe(32'h700 + n, n);
    drain("t6_nomarker");
    markers(16);
    for (int n = 0; n < 64; n++) begin
      exp_q.push_back(smp(32'h800 + n, n, n == 63));
      strobe(32'h800 + n, n);
    end
    drain("t6");
    check("t6_sync_count", 32'(n_sync), 1);
    check("t6_ovf", 32'(overflow), 0);
`ifdef FAST_SQUARE_FRAME_RX_STATS_EN
    check("t6_fc", 32'(frame_count), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
